result_byte_tx: RTL and testbench

Transmit-side companion to the 32-bit signed summation datapaths. It accepts one registered result word per transaction on a valid/ready handshake. It then streams the word out as bytes, most-significant byte first, on a second valid/ready handshake, with a last-byte flag. It sits after the output SREG of a datapath and drives a byte-wide link or capture interface.

---
 rtl/result_tx_pkg.sv | 23 ++
 rtl/byte_shift_reg.sv | 32 +++
 rtl/result_byte_tx.sv | 135 +++++++++++++
 tb/tb_result_byte_tx.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_tx_pkg.sv
// Shared definitions for the result byte transmitter: FSM state encoding,
// byte width and helpers deriving the per-word byte count and counter width.
package result_tx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CHK  = 2'd2
  } state_t;

  // Number of bytes in one result word.
  function automatic int num_bytes(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Width of the byte counter that walks 0 .. num_bytes-1.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w / BYTE_W);
  endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// Parallel-load register that shifts left by one byte per shift request and
// otherwise holds. Only the most-significant byte is visible outside; the
// lower bytes move up into it as the word is streamed out.
module byte_shift_reg
  import result_tx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic [BYTE_W-1:0] o_msb_byte
);

  logic [DATA_W-1:0] r_shreg;

  // Load wins over shift; with neither request the contents hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  assign o_msb_byte = r_shreg[DATA_W-1 -: BYTE_W];

endmodule

// File: rtl/result_byte_tx.sv
// Streams one registered result word out as bytes, MSB first.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and ready
// are both high. in_ready depends on state only; out_data/out_valid/out_last
// are decoded from state and registers only, never from out_ready/in_valid.
//
// Optional build macro RESULT_TX_CHECKSUM_EN appends an XOR checksum byte
// after the data bytes and moves out_last onto it.
module result_byte_tx
  import result_tx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int NUM_BYTES = num_bytes(DATA_W);
  localparam int CNT_W     = cnt_width(DATA_W);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BYTE_W-1:0]   w_msb_byte;
  logic                w_word_acc;
  logic                w_byte_acc;
  logic                w_last_byte;

  assign w_word_acc  = (r_state == ST_IDLE) && in_valid;
  assign w_byte_acc  = (r_state == ST_SEND) && out_ready;
  assign w_last_byte = (r_cnt == CNT_W'(NUM_BYTES - 1));

  byte_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shreg (
    .clk        (Clk),
    .rst_n      (rst),
    .i_load     (w_word_acc),
    .i_shift    (w_byte_acc),
    .i_data     (in_data),
    .o_msb_byte (w_msb_byte)
  );

`ifdef RESULT_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] r_chk;

  // Running XOR of the data bytes, restarted with every new word.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_chk <= '0;
    end else if (w_word_acc) begin
      r_chk <= '0;
    end else if (w_byte_acc) begin
      r_chk <= r_chk ^ w_msb_byte;
    end
  end
`endif

  // State register.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Byte counter: cleared on word accept, advanced on every data byte accept.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_word_acc) begin
      r_cnt <= '0;
    end else if (w_byte_acc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Next-state and output decode; outputs use only state and registers.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = w_msb_byte;
`ifdef RESULT_TX_CHECKSUM_EN
        if (out_ready && w_last_byte) begin
          w_next_state = ST_CHK;
        end
`else
        out_last = w_last_byte;
        if (out_ready && w_last_byte) begin
          w_next_state = ST_IDLE;
        end
`endif
      end
`ifdef RESULT_TX_CHECKSUM_EN
      ST_CHK: begin
        out_valid = 1'b1;
        out_data  = r_chk;
        out_last  = 1'b1;
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_result_byte_tx.sv
// Directed bench for result_byte_tx: a 32-bit instance for the main scenarios
// and a 16-bit instance for the width parameter. Expected frames follow the
// RESULT_TX_CHECKSUM_EN build setting.
module tb_result_byte_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (32-bit) ----------------
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [1:0]  dbg_state;

  result_byte_tx #(.DATA_W(32)) u_dut (
    .Clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- DUT (16-bit) ----------------
  logic [15:0] in_data16;
  logic        in_valid16;
  logic        in_ready16;
  logic [7:0]  out_data16;
  logic        out_valid16;
  logic        out_ready16;
  logic        out_last16;
  logic        busy16;
  logic [1:0]  dbg_state16;

  result_byte_tx #(.DATA_W(16)) u_dut16 (
    .Clk       (clk),
    .rst       (rst),
    .in_data   (in_data16),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .out_data  (out_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_last  (out_last16),
    .busy      (busy16),
    .dbg_state (dbg_state16)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  logic [7:0] got_q[$];
  bit         got_last_q[$];
  logic [7:0] held_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         frame_cycles;
  bit         frame_done;
  bit         acc_ok;
  int         acc_cyc;

  // ---------------- driver tasks ----------------
  // Presents a word until in_ready is seen, returns at posedge+1 after accept.
  task automatic accept_word(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    acc_ok   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!acc_ok) begin
        @(negedge clk);
        if (in_ready) acc_ok = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
    end
    if (acc_ok) begin
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  // Collects bytes until out_last (bounded); stalls byte stall_idx for stall_n cycles.
  task automatic collect_frame(input int stall_idx, input int stall_n);
    int idx;
    int stall;
    idx = 0;
    stall = 0;
    frame_done = 1'b0;
    frame_cycles = 0;
    got_q.delete();
    got_last_q.delete();
    held_q.delete();
    for (int c = 0; c < 40; c++) begin
      if (!frame_done) begin
        out_ready = (idx == stall_idx && stall < stall_n) ? 1'b0 : 1'b1;
        @(negedge clk);
        frame_cycles++;
        if (out_valid) begin
          if (!out_ready) begin
            held_q.push_back(out_data);
            stall++;
          end else begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
            idx++;
            if (out_last) frame_done = 1'b1;
          end
        end
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    accept_word(32'h12345678);
    n_vec++; if (acc_ok !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b expected 1", acc_ok); end
    collect_frame(-1, 0);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL basic_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if ({got_last_q[i], got_q[i]} !== {exp_last_q[i], exp_q[i]}) begin
        n_err++; $display("FAIL basic_byte%0d: got %b/%h expected %b/%h", i, got_last_q[i], got_q[i], exp_last_q[i], exp_q[i]);
      end
    end
    n_vec++; if (frame_cycles !== exp_q.size()) begin n_err++; $display("FAIL basic_cycles: got %0d expected %0d", frame_cycles, exp_q.size()); end
    @(negedge clk);
    n_vec++; if ({in_ready, busy} !== 2'b10) begin n_err++; $display("FAIL basic_idle_after: got ready/busy %b expected 10", {in_ready, busy}); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7E};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{8'h80, 8'hFF, 8'h00, 8'h01};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    accept_word(32'h80FF0001);
    n_vec++; if (acc_ok !== 1'b1) begin n_err++; $display("FAIL bp_accept: got %b expected 1", acc_ok); end
    collect_frame(1, 3);
    n_vec++; if (held_q.size() !== 3) begin n_err++; $display("FAIL bp_stall_cycles: got %0d expected 3", held_q.size()); end
    foreach (held_q[i]) begin
      n_vec++; if (held_q[i] !== 8'hFF) begin n_err++; $display("FAIL bp_held%0d: got %h expected ff", i, held_q[i]); end
    end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if ({got_last_q[i], got_q[i]} !== {exp_last_q[i], exp_q[i]}) begin
        n_err++; $display("FAIL bp_byte%0d: got %b/%h expected %b/%h", i, got_last_q[i], got_q[i], exp_last_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    int first_bytes;
    bit second_seen;
    logic [7:0] b2b_q[$];
    acc2 = -1;
    second_seen = 1'b0;
    accept_word(32'hAAAAAAAA);
    n_vec++; if (acc_ok !== 1'b1) begin n_err++; $display("FAIL b2b_accept1: got %b expected 1", acc_ok); end
    acc1 = acc_cyc;
    in_data = 32'h55555555;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!second_seen) begin
        @(negedge clk);
        if (in_ready) begin
          @(posedge clk); #1;
          acc2 = cyc;
          second_seen = 1'b1;
          in_valid = 1'b0;
        end else begin
          if (out_valid) b2b_q.push_back(out_data);
          @(posedge clk); #1;
        end
      end
    end
    in_valid = 1'b0;
    first_bytes = b2b_q.size();
`ifdef RESULT_TX_CHECKSUM_EN
    n_vec++; if (acc2 - acc1 !== 6) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 6", acc2 - acc1); end
    n_vec++; if (first_bytes !== 5) begin n_err++; $display("FAIL b2b_first_len: got %0d expected 5", first_bytes); end
`else
    n_vec++; if (acc2 - acc1 !== 5) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 5", acc2 - acc1); end
    n_vec++; if (first_bytes !== 4) begin n_err++; $display("FAIL b2b_first_len: got %0d expected 4", first_bytes); end
`endif
    for (int i = 0; i < 4 && i < first_bytes; i++) begin
      n_vec++; if (b2b_q[i] !== 8'hAA) begin n_err++; $display("FAIL b2b_first%0d: got %h expected aa", i, b2b_q[i]); end
    end
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h00};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{8'h55, 8'h55, 8'h55, 8'h55};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    collect_frame(-1, 0);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_second_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if ({got_last_q[i], got_q[i]} !== {exp_last_q[i], exp_q[i]}) begin
        n_err++; $display("FAIL b2b_second%0d: got %b/%h expected %b/%h", i, got_last_q[i], got_q[i], exp_last_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    accept_word(32'hDEADBEEF);
    n_vec++; if (acc_ok !== 1'b1) begin n_err++; $display("FAIL mfr_accept: got %b expected 1", acc_ok); end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if ({out_valid, out_data} !== {1'b1, 8'hDE}) begin n_err++; $display("FAIL mfr_byte0: got %b/%h expected 1/de", out_valid, out_data); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if ({out_valid, out_data} !== {1'b1, 8'hAD}) begin n_err++; $display("FAIL mfr_byte1: got %b/%h expected 1/ad", out_valid, out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_data, out_last, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL mfr_outputs: got rdy/vld/data/last/busy %b/%b/%h/%b/%b expected 1/0/00/0/0", in_ready, out_valid, out_data, out_last, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h01};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    accept_word(32'h00000001);
    n_vec++; if (acc_ok !== 1'b1) begin n_err++; $display("FAIL mfr_accept2: got %b expected 1", acc_ok); end
    collect_frame(-1, 0);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL mfr_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if ({got_last_q[i], got_q[i]} !== {exp_last_q[i], exp_q[i]}) begin
        n_err++; $display("FAIL mfr_byte_after%0d: got %b/%h expected %b/%h", i, got_last_q[i], got_q[i], exp_last_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_word();
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    accept_word(32'h00000000);
    n_vec++; if (acc_ok !== 1'b1) begin n_err++; $display("FAIL zero_accept: got %b expected 1", acc_ok); end
    collect_frame(-1, 0);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL zero_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if ({got_last_q[i], got_q[i]} !== {exp_last_q[i], exp_q[i]}) begin
        n_err++; $display("FAIL zero_byte%0d: got %b/%h expected %b/%h", i, got_last_q[i], got_q[i], exp_last_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_width16();
    logic [7:0] w_q[$];
    bit         l_q[$];
    bit         ok;
    bit         done;
    ok = 1'b0;
    done = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q = '{8'hBE, 8'hEF, 8'h51};
    exp_last_q = '{1'b0, 1'b0, 1'b1};
`else
    exp_q = '{8'hBE, 8'hEF};
    exp_last_q = '{1'b0, 1'b1};
`endif
    in_data16 = 16'hBEEF;
    in_valid16 = 1'b1;
    out_ready16 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!ok) begin
        @(negedge clk);
        if (in_ready16) ok = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid16 = 1'b0;
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL w16_accept: got %b expected 1", ok); end
    for (int c = 0; c < 20; c++) begin
      if (!done) begin
        @(negedge clk);
        if (out_valid16) begin
          w_q.push_back(out_data16);
          l_q.push_back(out_last16);
          if (out_last16) done = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    n_vec++; if (w_q.size() !== exp_q.size()) begin n_err++; $display("FAIL w16_len: got %0d expected %0d", w_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < w_q.size(); i++) begin
      n_vec++;
      if ({l_q[i], w_q[i]} !== {exp_last_q[i], exp_q[i]}) begin
        n_err++; $display("FAIL w16_byte%0d: got %b/%h expected %b/%h", i, l_q[i], w_q[i], exp_last_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_frame_reset();
    test_zero_word();
    test_width16();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
